// File: rtl/ysyx_041461_pipe_ctrl.sv
// ============================================================================
// Module  : ysyx_041461_pipe_ctrl
// Brief   : 6-stage pipeline stall/flush control, trap drain sequencing, PC redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_041461_pipe_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_IF_busy,
    input  logic              PC_MEM_busy,
    input  logic              CD_ID_conflict,
    input  logic              CD_EXE_conflict,
    input  logic              CD_MEM_conflict,
    input  logic              CD_IF_trap,
    input  logic              CD_IF2_trap,
    input  logic              CD_ID_trap,
    input  logic              CD_EXE_trap,
    input  logic              CD_MEM_trap,
    input  logic              PC_ID_br_taken,
    input  logic [ADDR_W-1:0] PC_ID_br_target,
    input  logic              PC_WB_trap_valid,
    input  logic [ADDR_W-1:0] PC_WB_trap_target,
    output logic              PC_IF_stall,
    output logic              PC_IF2_stall,
    output logic              PC_ID_stall,
    output logic              PC_EXE_stall,
    output logic              PC_MEM_stall,
    output logic              PC_IF2_flush,
    output logic              PC_ID_flush,
    output logic              PC_EXE_flush,
    output logic              PC_MEM_flush,
    output logic              PC_WB_flush,
    output logic              PC_redirect_valid,
    output logic [ADDR_W-1:0] PC_redirect_pc,
    output logic [1:0]        PC_state,
    output logic [CNT_W-1:0]  PC_stall_cnt,
    output logic [CNT_W-1:0]  PC_trap_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [ADDR_W-1:0] r_trap_target;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_trap_cnt;

    logic w_mem_stall, w_exe_stall, w_id_stall, w_if2_stall, w_if_stall;
    logic w_in_run, w_busy, w_trap_take, w_br_take;

    // Raw hazard chain; only driven onto the outputs while in RUN.
    assign w_mem_stall = PC_MEM_busy | CD_MEM_conflict;
    assign w_exe_stall = w_mem_stall | CD_EXE_conflict;
    assign w_id_stall  = w_exe_stall | CD_ID_conflict;
    assign w_if2_stall = w_id_stall;
    assign w_if_stall  = w_if2_stall | PC_IF_busy;

    assign w_in_run    = (r_state == S_RUN);
    assign w_busy      = PC_IF_busy | PC_MEM_busy;
    assign w_trap_take = w_in_run & PC_WB_trap_valid;
    assign w_br_take   = w_in_run & PC_ID_br_taken & ~w_id_stall & ~PC_WB_trap_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_RUN;
        case (r_state)
            S_RUN:      w_next_state = PC_WB_trap_valid ? (w_busy ? S_DRAIN : S_REDIRECT) : S_RUN;
            S_DRAIN:    w_next_state = w_busy ? S_DRAIN : S_REDIRECT;
            S_REDIRECT: w_next_state = S_RUN;
            default:    w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        PC_IF_stall  = 1'b0;
        PC_IF2_stall = 1'b0;
        PC_ID_stall  = 1'b0;
        PC_EXE_stall = 1'b0;
        PC_MEM_stall = 1'b0;
        PC_IF2_flush = 1'b1;
        PC_ID_flush  = 1'b1;
        PC_EXE_flush = 1'b1;
        PC_MEM_flush = 1'b1;
        PC_WB_flush  = 1'b1;
        if (w_in_run) begin
            PC_IF_stall  = w_if_stall;
            PC_IF2_stall = w_if2_stall;
            PC_ID_stall  = w_id_stall;
            PC_EXE_stall = w_exe_stall;
            PC_MEM_stall = w_mem_stall;
            // r_redirect_valid in RUN can only come from a branch accepted last cycle.
            PC_IF2_flush = (w_if_stall & ~w_if2_stall) | CD_IF_trap | w_trap_take | w_br_take
                         | r_redirect_valid;
            PC_ID_flush  = CD_IF2_trap | w_trap_take | w_br_take;
            PC_EXE_flush = (w_id_stall & ~w_exe_stall) | CD_ID_trap | w_trap_take;
            PC_MEM_flush = (w_exe_stall & ~w_mem_stall) | CD_EXE_trap | w_trap_take;
            PC_WB_flush  = w_mem_stall | CD_MEM_trap | w_trap_take;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_trap_target    <= '0;
            r_stall_cnt      <= '0;
            r_trap_cnt       <= '0;
        end else begin
            r_redirect_valid <= w_br_take | (w_next_state == S_REDIRECT);
            if (w_br_take) begin
                r_redirect_pc <= PC_ID_br_target;
            end else if (w_next_state == S_REDIRECT) begin
                r_redirect_pc <= w_in_run ? PC_WB_trap_target : r_trap_target;
            end
            if (w_trap_take) begin
                r_trap_target <= PC_WB_trap_target;
            end
            if (w_in_run && w_if_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_trap_take && !(&r_trap_cnt)) begin
                r_trap_cnt <= r_trap_cnt + CNT_W'(1);
            end
        end
    end

    assign PC_redirect_valid = r_redirect_valid;
    assign PC_redirect_pc    = r_redirect_pc;
    assign PC_state          = r_state;
    assign PC_stall_cnt      = r_stall_cnt;
    assign PC_trap_cnt       = r_trap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// ============================================================================
// Module  : tb_ysyx_041461_pipe_ctrl
// Brief   : Directed + randomized self-checking bench against a stage-depth model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_041461_pipe_ctrl;

    localparam int CW = 4;
    localparam int AW = 64;
    localparam int CMAX = (1 << CW) - 1;

    logic clk, rst;
    logic if_busy, mem_busy, id_conf, exe_conf, mem_conf;
    logic [4:0] trapv;  // {MEM,EXE,ID,IF2,IF} kill requests
    logic br, wbtv;
    logic [AW-1:0] br_tgt, wb_tgt;

    logic s_if, s_if2, s_id, s_exe, s_mem;
    logic f_if2, f_id, f_exe, f_mem, f_wb;
    logic rv;
    logic [AW-1:0] rpc;
    logic [1:0] st;
    logic [CW-1:0] scnt, tcnt;

    int checks = 0;
    int errors = 0;

    // Model state (modes: 0 run, 1 drain, 2 redirect)
    int m_mode, m_scnt, m_tcnt;
    logic m_rv;
    logic [AW-1:0] m_rpc, m_tgt;

    ysyx_041461_pipe_ctrl #(.CNT_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .PC_IF_busy(if_busy), .PC_MEM_busy(mem_busy),
        .CD_ID_conflict(id_conf), .CD_EXE_conflict(exe_conf), .CD_MEM_conflict(mem_conf),
        .CD_IF_trap(trapv[0]), .CD_IF2_trap(trapv[1]), .CD_ID_trap(trapv[2]),
        .CD_EXE_trap(trapv[3]), .CD_MEM_trap(trapv[4]),
        .PC_ID_br_taken(br), .PC_ID_br_target(br_tgt),
        .PC_WB_trap_valid(wbtv), .PC_WB_trap_target(wb_tgt),
        .PC_IF_stall(s_if), .PC_IF2_stall(s_if2), .PC_ID_stall(s_id),
        .PC_EXE_stall(s_exe), .PC_MEM_stall(s_mem),
        .PC_IF2_flush(f_if2), .PC_ID_flush(f_id), .PC_EXE_flush(f_exe),
        .PC_MEM_flush(f_mem), .PC_WB_flush(f_wb),
        .PC_redirect_valid(rv), .PC_redirect_pc(rpc), .PC_state(st),
        .PC_stall_cnt(scnt), .PC_trap_cnt(tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] dut_stall = {s_mem, s_exe, s_id, s_if2, s_if};
    wire [4:0] dut_flush = {f_wb, f_mem, f_exe, f_id, f_if2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stall depth = number of stages (from IF) that hold; the bubble goes into the first moving stage.
    function automatic int depth();
        if (mem_busy | mem_conf) return 5;
        if (exe_conf)            return 4;
        if (id_conf)             return 3;
        if (if_busy)             return 1;
        return 0;
    endfunction

    function automatic logic br_accept();
        return (m_mode == 0) && br && (depth() < 3) && !wbtv;
    endfunction

    task automatic model_out(output logic [4:0] es, output logic [4:0] ef);
        int d;
        d = depth();
        es = '0;
        ef = 5'b11111;
        if (m_mode == 0) begin
            es = 5'((1 << d) - 1);
            ef = trapv;
            if (d > 0) ef[d-1] = 1'b1;
            if (wbtv) ef = 5'b11111;
            if (br_accept()) ef = ef | 5'b00011;
            if (m_rv) ef[0] = 1'b1;
        end
    endtask

    task automatic cyc();
        logic [4:0] es, ef;
        #4;
        model_out(es, ef);
        chk("state", 64'(st), 64'(m_mode));
        chk("redirect_valid", 64'(rv), 64'(m_rv));
        if (m_rv) chk("redirect_pc", rpc, m_rpc);
        chk("stall_cnt", 64'(scnt), 64'(m_scnt));
        chk("trap_cnt", 64'(tcnt), 64'(m_tcnt));
        chk("stall_vec", 64'(dut_stall), 64'(es));
        chk("flush_vec", 64'(dut_flush), 64'(ef));
    endtask

    task automatic model_reset();
        m_mode = 0; m_rv = 1'b0; m_rpc = '0; m_tgt = '0; m_scnt = 0; m_tcnt = 0;
    endtask

    task automatic adv();
        logic busy, acc;
        busy = if_busy | mem_busy;
        acc = br_accept();
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                0: begin
                    if (depth() > 0 && m_scnt < CMAX) m_scnt++;
                    m_rv = 1'b0;
                    if (wbtv) begin
                        if (m_tcnt < CMAX) m_tcnt++;
                        m_tgt = wb_tgt;
                        if (busy) m_mode = 1;
                        else begin m_mode = 2; m_rv = 1'b1; m_rpc = wb_tgt; end
                    end else if (acc) begin
                        m_rv = 1'b1; m_rpc = br_tgt;
                    end
                end
                1: begin
                    m_rv = 1'b0;
                    if (!busy) begin m_mode = 2; m_rv = 1'b1; m_rpc = m_tgt; end
                end
                default: begin m_mode = 0; m_rv = 1'b0; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_busy = 0; mem_busy = 0; id_conf = 0; exe_conf = 0; mem_conf = 0;
        trapv = '0; br = 0; wbtv = 0; br_tgt = '0; wb_tgt = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        cyc();
        chk("reset_stall", 64'(dut_stall), 64'd0);
        chk("reset_flush", 64'(dut_flush), 64'd0);
        adv();
        rst = 1'b0;

        // EXE conflict for two cycles
        exe_conf = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("exe_conf_stall", 64'(dut_stall), 64'h0F);
            chk("exe_conf_flush", 64'(dut_flush), 64'h08);
            adv();
        end
        exe_conf = 0;
        cyc();
        chk("exe_conf_cnt", 64'(scnt), 64'd2);
        adv();

        // MEM busy for three cycles then release
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mem_busy_stall", 64'(dut_stall), 64'h1F);
            chk("mem_busy_flush", 64'(dut_flush), 64'h10);
            adv();
        end
        mem_busy = 0;
        cyc();
        chk("mem_release_stall", 64'(dut_stall), 64'h00);
        adv();

        // Taken branch
        br = 1; br_tgt = 64'h8000_0100;
        cyc();
        chk("br_flush_t", 64'(dut_flush), 64'h03);
        adv();
        br = 0; br_tgt = '0;
        cyc();
        chk("br_rv_t1", 64'(rv), 64'd1);
        chk("br_pc_t1", rpc, 64'h8000_0100);
        chk("br_flush_t1", 64'(dut_flush), 64'h01);
        adv();
        cyc();
        chk("br_rv_t2", 64'(rv), 64'd0);
        adv();

        // Trap and branch in the same cycle
        wbtv = 1; wb_tgt = 64'h8000_0000; br = 1; br_tgt = 64'h1234;
        cyc();
        chk("trap_flush", 64'(dut_flush), 64'h1F);
        adv();
        idle();
        cyc();
        chk("trap_state", 64'(st), 64'd2);
        chk("trap_pc", rpc, 64'h8000_0000);
        chk("trap_cnt", 64'(tcnt), 64'd1);
        adv();
        cyc();
        chk("trap_back_run", 64'(st), 64'd0);
        adv();

        // Trap while MEM busy: four DRAIN cycles
        wbtv = 1; wb_tgt = 64'h8000_0040; mem_busy = 1;
        cyc();
        adv();
        wbtv = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_busy = 0;
            cyc();
            chk("drain_state", 64'(st), 64'd1);
            chk("drain_flush", 64'(dut_flush), 64'h1F);
            chk("drain_stall", 64'(dut_stall), 64'h00);
            adv();
        end
        cyc();
        chk("drain_redirect", 64'(st), 64'd2);
        chk("drain_pc", rpc, 64'h8000_0040);
        adv();
        cyc();
        chk("drain_run", 64'(st), 64'd0);
        adv();

        // Reset in the middle of DRAIN
        wbtv = 1; if_busy = 1;
        cyc(); adv();
        wbtv = 0;
        cyc(); adv();
        rst = 1;
        cyc(); adv();
        rst = 0; if_busy = 0;
        cyc();
        chk("rst_drain_state", 64'(st), 64'd0);
        chk("rst_drain_rv", 64'(rv), 64'd0);
        chk("rst_drain_scnt", 64'(scnt), 64'd0);
        chk("rst_drain_tcnt", 64'(tcnt), 64'd0);
        adv();

        // Stall counter saturation
        if_busy = 1;
        for (int i = 0; i < CMAX + 5; i++) begin cyc(); adv(); end
        if_busy = 0;
        cyc();
        chk("scnt_saturate", 64'(scnt), 64'(CMAX));
        adv();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            if_busy  = ($urandom_range(0, 3) == 0);
            mem_busy = ($urandom_range(0, 4) == 0);
            id_conf  = ($urandom_range(0, 7) == 0);
            exe_conf = ($urandom_range(0, 7) == 0);
            mem_conf = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 5; k++) trapv[k] = ($urandom_range(0, 15) == 0);
            br       = ($urandom_range(0, 3) == 0);
            wbtv     = ($urandom_range(0, 11) == 0);
            br_tgt   = {$urandom, $urandom};
            wb_tgt   = {$urandom, $urandom};
            cyc();
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
